// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: input conditioning, IDLE/RUN/PAUSE/ADJUST sequencing and
// timing enables for the lab3 stopwatch counters and display mux.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnP,
    input  logic       btnR,
    input  logic [7:0] sw,
    output logic       count_en,
    output logic       clr,
    output logic       adj_mode,
    output logic       adj_sel,
    output logic       blink,
    output logic       running,
    output logic       scan_en,
    output logic [1:0] state
);

    localparam int PMAX = (TICK_DIV > ADJ_DIV) ? TICK_DIV : ADJ_DIV;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int DW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0]  TICK_TERM  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  ADJ_TERM   = PW'(ADJ_DIV - 1);
    localparam logic [DW-1:0]  DB_TERM    = DW'(DB_CYCLES - 1);
    localparam logic [BW-1:0]  BLINK_TERM = BW'(BLINK_DIV - 1);
    localparam logic [SCW-1:0] SCAN_TERM  = SCW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSE  = 2'b10,
        ADJUST = 2'b11
    } state_t;

    logic unused_sw;
    assign unused_sw = ^sw[7:2];

    // bit order: {SEL, ADJ, btnR, btnP}
    logic [3:0]          s1_q, s1_d, s2_q, s2_d;
    logic [1:0]          db_q, db_d, press_q, press_d;
    logic [1:0][DW-1:0]  dbc_q, dbc_d;
    state_t              state_q, state_d;
    logic                clr_q, clr_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                ce;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                blink_q, blink_d;
    logic [SCW-1:0]      scnt_q, scnt_d;
    logic                scan_q, scan_d;
    logic                running_q, running_d;
    logic                adj_mode_q, adj_mode_d;
    logic                adj_sel_q, adj_sel_d;
    logic                adj, sel, p_ev, r_ev;
    logic                in_adj_q, in_adj_d;

    always_comb begin
        s1_d = {sw[1], sw[0], btnR, btnP};
        s2_d = s1_q;
    end

    always_comb begin
        db_d    = db_q;
        dbc_d   = '0;
        press_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (dbc_q[i] == DB_TERM) begin
                    db_d[i] = s2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + 1'b1;
                end
            end
            press_d[i] = db_d[i] & ~db_q[i];
        end
    end

    assign adj  = s2_q[2];
    assign sel  = s2_q[3];
    assign p_ev = press_q[0];
    assign r_ev = press_q[1];

    // clear wins over the ADJ switch, which wins over the pause button
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (r_ev) begin
            clr_d   = 1'b1;
            state_d = adj ? ADJUST : IDLE;
        end else if (adj && state_q != ADJUST) begin
            state_d = ADJUST;
        end else if (!adj && state_q == ADJUST) begin
            state_d = PAUSE;
        end else if (p_ev) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    assign in_adj_q = (state_q == ADJUST);
    assign in_adj_d = (state_d == ADJUST);

    always_comb begin
        presc_d = presc_q;
        ce      = 1'b0;
        if (state_q == RUN) begin
            if (presc_q == TICK_TERM) begin
                presc_d = '0;
                ce      = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_q == ADJUST) begin
            if (presc_q == ADJ_TERM) begin
                presc_d = '0;
                ce      = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (clr_d || (in_adj_d != in_adj_q)) begin
            presc_d = '0;
        end
    end

    always_comb begin
        blink_d = 1'b1;
        bcnt_d  = '0;
        if (in_adj_d && in_adj_q) begin
            if (bcnt_q == BLINK_TERM) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        scan_d = 1'b0;
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == SCAN_TERM) begin
            scan_d = 1'b1;
            scnt_d = '0;
        end
    end

    always_comb begin
        running_d  = (state_d == RUN);
        adj_mode_d = in_adj_d;
        adj_sel_d  = in_adj_d & sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            dbc_q      <= '0;
            press_q    <= '0;
            state_q    <= IDLE;
            clr_q      <= 1'b0;
            presc_q    <= '0;
            bcnt_q     <= '0;
            blink_q    <= 1'b1;
            scnt_q     <= '0;
            scan_q     <= 1'b0;
            running_q  <= 1'b0;
            adj_mode_q <= 1'b0;
            adj_sel_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            dbc_q      <= dbc_d;
            press_q    <= press_d;
            state_q    <= state_d;
            clr_q      <= clr_d;
            presc_q    <= presc_d;
            bcnt_q     <= bcnt_d;
            blink_q    <= blink_d;
            scnt_q     <= scnt_d;
            scan_q     <= scan_d;
            running_q  <= running_d;
            adj_mode_q <= adj_mode_d;
            adj_sel_q  <= adj_sel_d;
        end
    end

    assign count_en = ce & ~clr_q;
    assign clr      = clr_q;
    assign state    = state_q;
    assign blink    = blink_q;
    assign scan_en  = scan_q;
    assign running  = running_q;
    assign adj_mode = adj_mode_q;
    assign adj_sel  = adj_sel_q;

endmodule
